pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage pipeline (F,D,E,M,W).

---
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/pipeline_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_if : hazard/match inputs and stall/flush/forward outputs
// Rev 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             Match_1E_M;
    logic             Match_1E_W;
    logic             Match_2E_M;
    logic             Match_2E_W;
    logic             Match_12D_E;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             PCSrcD;
    logic             PCSrcE;
    logic             PCSrcM;
    logic             PCSrcW;
    logic             BranchTakenE;
    logic             MemReqM;
    logic             MemReady;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             EnM;
    logic             EnW;
    logic             MemFault;
    logic [CNT_W-1:0] StallCount;

    // master = pipeline datapath side, slave = hazard controller
    modport master (
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReady,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               EnM, EnW, MemFault, StallCount
    );

    modport slave (
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReady,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               EnM, EnW, MemFault, StallCount
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : 5-stage hazard, forwarding and memory-freeze control
// Rev 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [15:0]      c_WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    state_t           state_q;
    logic [15:0]      wait_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_ldr;
    logic       w_pcwp;
    logic       w_freeze;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_flush_d;
    logic       w_flush_e;
    logic       w_en;

    always_comb begin
        w_fwd_a = 2'b00;
        if (hz.Match_1E_M && hz.RegWriteM)      w_fwd_a = 2'b10;
        else if (hz.Match_1E_W && hz.RegWriteW) w_fwd_a = 2'b01;

        w_fwd_b = 2'b00;
        if (hz.Match_2E_M && hz.RegWriteM)      w_fwd_b = 2'b10;
        else if (hz.Match_2E_W && hz.RegWriteW) w_fwd_b = 2'b01;

        w_ldr  = hz.Match_12D_E && hz.MemtoRegE;
        w_pcwp = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;

        // MemReady in MWAIT releases the freeze in the completing cycle itself
        w_freeze = (state_q == ST_FAULT) ||
                   (!hz.MemReady && ((state_q == ST_MWAIT) || hz.MemReqM));

        if (w_freeze) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_d = 1'b0;
            w_flush_e = 1'b0;
            w_en      = 1'b0;
        end else begin
            w_stall_f = w_ldr || w_pcwp;
            w_stall_d = w_ldr;
            w_flush_d = w_pcwp || hz.PCSrcW || hz.BranchTakenE;
            w_flush_e = w_ldr || hz.BranchTakenE;
            w_en      = 1'b1;
        end
    end

    assign hz.ForwardAE  = w_fwd_a;
    assign hz.ForwardBE  = w_fwd_b;
    assign hz.StallF     = w_stall_f;
    assign hz.StallD     = w_stall_d;
    assign hz.FlushD     = w_flush_d;
    assign hz.FlushE     = w_flush_e;
    assign hz.EnM        = w_en;
    assign hz.EnW        = w_en;
    assign hz.MemFault   = (state_q == ST_FAULT);
    assign hz.StallCount = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_q      <= 16'd0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz.MemReqM && !hz.MemReady) begin
                        state_q <= ST_MWAIT;
                        wait_q  <= 16'd1;
                    end
                end
                ST_MWAIT: begin
                    if (hz.MemReady)                state_q <= ST_RUN;
                    else if (wait_q == c_WAIT_LAST) state_q <= ST_FAULT;
                    else                            wait_q  <= wait_q + 16'd1;
                end
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_FAULT;
            endcase

            if (w_stall_f && (stall_cnt_q != c_CNT_MAX))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl : directed + random bench for two controller sizes
// Rev 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic m1em, m1ew, m2em, m2ew, m12de, rwm, rww, mtre;
        logic pcd, pce, pcm, pcw, bt, req, ready;
    } in_t;

    logic clk;
    logic reset;
    in_t  in_v;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: MEM_TIMEOUT=6, CNT_W=16. Instance 1: MEM_TIMEOUT=4, CNT_W=2.
    pipeline_hazard_ctrl_if #(.CNT_W(16)) if0 ();
    pipeline_hazard_ctrl_if #(.CNT_W(2))  if1 ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(6), .CNT_W(16)) u_dut0 (.clk(clk), .reset(reset), .hz(if0));
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2))  u_dut1 (.clk(clk), .reset(reset), .hz(if1));

    assign {if0.Match_1E_M, if0.Match_1E_W, if0.Match_2E_M, if0.Match_2E_W, if0.Match_12D_E,
            if0.RegWriteM, if0.RegWriteW, if0.MemtoRegE, if0.PCSrcD, if0.PCSrcE, if0.PCSrcM,
            if0.PCSrcW, if0.BranchTakenE, if0.MemReqM, if0.MemReady} = in_v;
    assign {if1.Match_1E_M, if1.Match_1E_W, if1.Match_2E_M, if1.Match_2E_W, if1.Match_12D_E,
            if1.RegWriteM, if1.RegWriteW, if1.MemtoRegE, if1.PCSrcD, if1.PCSrcE, if1.PCSrcM,
            if1.PCSrcW, if1.BranchTakenE, if1.MemReqM, if1.MemReady} = in_v;

    // {FwdA[10:9], FwdB[8:7], StallF[6], StallD[5], FlushD[4], FlushE[3], EnM[2], EnW[1], MemFault[0]}
    logic [10:0] obs [2];
    logic [15:0] cnt_obs [2];
    assign obs[0] = {if0.ForwardAE, if0.ForwardBE, if0.StallF, if0.StallD, if0.FlushD,
                     if0.FlushE, if0.EnM, if0.EnW, if0.MemFault};
    assign obs[1] = {if1.ForwardAE, if1.ForwardBE, if1.StallF, if1.StallD, if1.FlushD,
                     if1.FlushE, if1.EnM, if1.EnW, if1.MemFault};
    assign cnt_obs[0] = if0.StallCount;
    assign cnt_obs[1] = {14'd0, if1.StallCount};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frozen-cycle count of the current access, fault flag, stall total.
    int tmo [2] = '{6, 4};
    int cap [2] = '{65535, 3};
    int frozen_n [2];
    bit faulted [2];
    int scnt [2];

    function automatic logic is_frozen(int k);
        return faulted[k] || (!in_v.ready && (frozen_n[k] > 0 || in_v.req));
    endfunction

    function automatic logic [10:0] exp_out(int k);
        logic [1:0] fa, fb;
        logic ldr, pcwp;
        fa = (in_v.m1em && in_v.rwm) ? 2'b10 : (in_v.m1ew && in_v.rww) ? 2'b01 : 2'b00;
        fb = (in_v.m2em && in_v.rwm) ? 2'b10 : (in_v.m2ew && in_v.rww) ? 2'b01 : 2'b00;
        ldr  = in_v.m12de && in_v.mtre;
        pcwp = in_v.pcd || in_v.pce || in_v.pcm;
        if (is_frozen(k))
            return {fa, fb, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, faulted[k]};
        return {fa, fb, ldr | pcwp, ldr, pcwp | in_v.pcw | in_v.bt, ldr | in_v.bt,
                1'b1, 1'b1, faulted[k]};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            frozen_n[k] = 0;
            faulted[k]  = 1'b0;
            scnt[k]     = 0;
        end
    endfunction

    function automatic void model_advance();
        for (int k = 0; k < 2; k++) begin
            logic [10:0] e;
            logic fr;
            e  = exp_out(k);
            fr = is_frozen(k);
            if (e[6] && scnt[k] < cap[k]) scnt[k]++;
            if (!faulted[k]) begin
                if (fr) begin
                    frozen_n[k]++;
                    if (frozen_n[k] == tmo[k]) faulted[k] = 1'b1;
                end else begin
                    frozen_n[k] = 0;
                end
            end
        end
    endfunction

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_v  = '0;
        #2;
        model_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_v  = '0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs[k] !== 11'b00_00_0000_110) begin
                n_errors++;
                $display("FAIL reset_out inst%0d got %b want %b", k, obs[k], 11'b00_00_0000_110);
            end
            n_checks++;
            if (cnt_obs[k] !== 16'd0) begin
                n_errors++;
                $display("FAIL reset_cnt inst%0d got %0d want 0", k, cnt_obs[k]);
            end
        end
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        in_v = '0;
        in_v.m1em = 1; in_v.rwm = 1; in_v.m1ew = 1; in_v.rww = 1;
        #1;
        n_checks++;
        if (if0.ForwardAE !== 2'b10) begin
            n_errors++;
            $display("FAIL fwd_m_prio got %b want 10", if0.ForwardAE);
        end
        in_v.rwm = 0;
        #1;
        n_checks++;
        if (if0.ForwardAE !== 2'b01) begin
            n_errors++;
            $display("FAIL fwd_w got %b want 01", if0.ForwardAE);
        end
        for (int v = 0; v < 64; v++) begin
            in_v = '0;
            {in_v.m1em, in_v.m1ew, in_v.m2em, in_v.m2ew, in_v.rwm, in_v.rww} = 6'(v);
            #1;
            n_checks++;
            if (obs[0] !== exp_out(0)) begin
                n_errors++;
                $display("FAIL fwd_sweep v=%0d got %b want %b", v, obs[0], exp_out(0));
            end
        end
        in_v = '0;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        in_v.m12de = 1; in_v.mtre = 1;
        #1;
        n_checks++;
        if (obs[0][6:3] !== 4'b1101) begin
            n_errors++;
            $display("FAIL ldr_stall got %b want 1101", obs[0][6:3]);
        end
        tick();
        in_v = '0;
        #1;
        n_checks++;
        if (obs[0][6] !== 1'b0 || cnt_obs[0] !== 16'd1) begin
            n_errors++;
            $display("FAIL ldr_after stallF=%b cnt=%0d want 0 and 1", obs[0][6], cnt_obs[0]);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        in_v.req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (obs[0][2] !== 1'b0 || obs[0][1] !== 1'b0 || obs[0][6] !== 1'b1) begin
                n_errors++;
                $display("FAIL mwait_frozen c%0d got EnM=%b EnW=%b StallF=%b want 0 0 1",
                         i, obs[0][2], obs[0][1], obs[0][6]);
            end
            tick();
        end
        in_v.ready = 1;
        #1;
        n_checks++;
        if (obs[0][2] !== 1'b1 || obs[1][2] !== 1'b1) begin
            n_errors++;
            $display("FAIL mwait_release got EnM=%b/%b want 1/1", obs[0][2], obs[1][2]);
        end
        tick();
        in_v = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cnt_obs[k] !== 16'd3) begin
                n_errors++;
                $display("FAIL mwait_cnt inst%0d got %0d want 3", k, cnt_obs[k]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        in_v.req = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (obs[1][0] !== (i >= 4) || obs[1][2] !== 1'b0) begin
                n_errors++;
                $display("FAIL timeout c%0d got fault=%b EnM=%b want %b 0",
                         i, obs[1][0], obs[1][2], (i >= 4));
            end
            n_checks++;
            if (obs[0] !== exp_out(0)) begin
                n_errors++;
                $display("FAIL timeout_big c%0d got %b want %b", i, obs[0], exp_out(0));
            end
            tick();
        end
        in_v = '0;
        in_v.ready = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs[k][0] !== 1'b1 || obs[k][2:1] !== 2'b00 || obs[k][6] !== 1'b1) begin
                n_errors++;
                $display("FAIL fault_sticky inst%0d got %b want fault=1 en=00 stallF=1",
                         k, obs[k]);
            end
        end
        tick();
    endtask

    task automatic test_branch_ldr();
        do_reset();
        in_v.bt = 1; in_v.m12de = 1; in_v.mtre = 1;
        #1;
        n_checks++;
        if (obs[0][4:3] !== 2'b11) begin
            n_errors++;
            $display("FAIL br_ldr_flush got %b want 11", obs[0][4:3]);
        end
        in_v = '0;
        in_v.req = 1;
        tick();
        in_v.bt = 1; in_v.m12de = 1; in_v.mtre = 1;
        #1;
        n_checks++;
        if (obs[0][4:3] !== 2'b00 || obs[0][6] !== 1'b1) begin
            n_errors++;
            $display("FAIL br_ldr_frozen got flush=%b stallF=%b want 00 1", obs[0][4:3], obs[0][6]);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        in_v.req = 1;
        tick();
        tick();
        reset = 1'b0;
        in_v  = '0;
        #1;
        model_reset();
        n_checks++;
        if (obs[0][2] !== 1'b1 || obs[0][0] !== 1'b0 || cnt_obs[0] !== 16'd0 ||
            cnt_obs[1] !== 16'd0) begin
            n_errors++;
            $display("FAIL rst_mid got EnM=%b fault=%b cnt=%0d/%0d want 1 0 0/0",
                     obs[0][2], obs[0][0], cnt_obs[0], cnt_obs[1]);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        in_v.m12de = 1; in_v.mtre = 1;
        for (int i = 0; i < 5; i++) tick();
        in_v = '0;
        #1;
        n_checks++;
        if (cnt_obs[1] !== 16'd3 || cnt_obs[0] !== 16'd5) begin
            n_errors++;
            $display("FAIL saturate got %0d/%0d want 5/3", cnt_obs[0], cnt_obs[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_v       = in_t'($urandom);
            in_v.req   = ($urandom_range(0, 9) < 3);
            in_v.ready = ($urandom_range(0, 9) < 5);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs[k] !== exp_out(k) || cnt_obs[k] !== 16'(scnt[k])) begin
                    n_errors++;
                    $display("FAIL random c%0d inst%0d got %b cnt %0d want %b cnt %0d",
                             c, k, obs[k], cnt_obs[k], exp_out(k), scnt[k]);
                end
            end
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (obs[k] !== exp_out(k) || cnt_obs[k] !== 16'd0) begin
                        n_errors++;
                        $display("FAIL random_rst c%0d inst%0d got %b cnt %0d want %b cnt 0",
                                 c, k, obs[k], cnt_obs[k], exp_out(k));
                    end
                end
                reset = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        in_v  = '0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_ldr();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
